// File: rtl/video_pattern_writer_pkg.sv
// Shared display types, pattern modes and the per-cell data encoding used by the pattern writer.
package video_package;

  typedef logic [11:0] disp_addr_t;
  typedef logic [15:0] disp_data_t;

  typedef enum logic [1:0] {PM_CLEAR, PM_FILL, PM_RAMP, PM_MSG} pattern_mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} writer_state_t;

  localparam int         MSG_LEN    = 32;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_STAR  = 8'h2A;

  // MSG rows alternate attribute bit 0 so neighbouring text lines are distinguishable.
  function automatic disp_data_t cell_data(pattern_mode_t mode, logic [7:0] attr,
                                           logic [7:0] ch, logic [7:0] k_lo,
                                           logic row_odd, logic [7:0] msg_ch);
    case (mode)
      PM_CLEAR: return {attr, CHAR_SPACE};
      PM_FILL:  return {attr, ch};
      PM_RAMP:  return {attr, k_lo};
      default:  return {attr ^ {7'b0, row_odd}, msg_ch};
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_writer_msg_rom.sv
// video_msg_rom: 32-entry combinational message lookup, character 0 first.
module video_msg_rom
  import video_package::*;
(
  input  logic [4:0] idx_i,
  output logic [7:0] char_o
);

  localparam logic [8*MSG_LEN-1:0] MSG_TEXT = "Hello from UPduino video!       ";

  assign char_o = MSG_TEXT[8*(MSG_LEN-1-int'(idx_i)) +: 8];

endmodule

// File: rtl/video_pattern_writer.sv
// video_pattern_writer: fills a len x ROWS display region with CLEAR/FILL/RAMP/MSG patterns.
// Define VIDEO_PATTERN_MSG_EN to build the message ROM; otherwise MSG mode writes asterisks.
module video_pattern_writer
  import video_package::*;
#(
  parameter int         FRAME_INTERVAL = 300,
  parameter int         ROWS           = 30,
  parameter disp_addr_t BASE_ADDR      = '0
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       eof_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  logic       auto_i,
  input  logic [7:0] attr_i,
  input  logic [7:0] fill_char_i,
  input  disp_addr_t pf_line_len_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       wr_en_o,
  output disp_addr_t wr_addr_o,
  output disp_data_t wr_data_o
);

  localparam int FW = (FRAME_INTERVAL > 1) ? $clog2(FRAME_INTERVAL) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_INTERVAL - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  writer_state_t state_q, state_d;
  pattern_mode_t mode_q, mode_d;
  logic [FW-1:0] frame_q, frame_d;
  disp_addr_t    len_q, len_d, col_q, col_d, k_q, k_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    attr_q, attr_d, char_q, char_d;
  logic          wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
  disp_addr_t    wr_addr_q, wr_addr_d;
  disp_data_t    wr_data_q, wr_data_d;
  logic [7:0]    msg_char;
  logic          eof_trig, trig, last_cell;

  assign eof_trig  = eof_i && (FRAME_INTERVAL != 0) && (frame_q == FRAME_LAST);
  assign trig      = (state_q == ST_IDLE) && (start_i || eof_trig);
  assign last_cell = (col_q == len_q - 1'b1) && (row_q == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      mode_q    <= pattern_mode_t'(mode_i);
      frame_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      frame_q   <= frame_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
    len_q  <= len_d;
    attr_q <= attr_d;
    char_q <= char_d;
    col_q  <= col_d;
    row_q  <= row_d;
    k_q    <= k_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (trig && (pf_line_len_i != '0)) state_d = ST_WRITE;
      ST_WRITE: if (last_cell) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output registers hold the write being presented, so next values describe the next cell.
  always_comb begin
    mode_d    = mode_q;
    frame_d   = frame_q;
    len_d     = len_q;
    attr_d    = attr_q;
    char_d    = char_q;
    col_d     = col_q;
    row_d     = row_q;
    k_d       = k_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eof_i) frame_d = eof_trig ? '0 : frame_q + 1'b1;
        if (trig) begin
          len_d  = pf_line_len_i;
          attr_d = attr_i;
          char_d = fill_char_i;
          if (!auto_i) mode_d = pattern_mode_t'(mode_i);
          col_d  = '0;
          row_d  = '0;
          k_d    = '0;
          if (pf_line_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            busy_d    = 1'b1;
            wr_addr_d = BASE_ADDR;
          end
        end
      end
      ST_WRITE: begin
        if (last_cell) begin
          done_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          busy_d    = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          k_d       = k_q + 1'b1;
          if (col_q == len_q - 1'b1) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: if (auto_i) mode_d = pattern_mode_t'(mode_q + 2'd1);
    endcase
  end

  always_comb begin
    wr_data_d = wr_data_q;
    if (wr_en_d) wr_data_d = cell_data(mode_d, attr_d, char_d, k_d[7:0], row_d[0], msg_char);
  end

`ifdef VIDEO_PATTERN_MSG_EN
  video_msg_rom u_msg_rom (
    .idx_i  (col_d[4:0]),
    .char_o (msg_char)
  );
`else
  assign msg_char = CHAR_STAR;
`endif

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule
